// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: button/tick inputs and display/control outputs of the
// 60-second timer sequencer, with master (driver) and slave (sequencer) views.
interface timer_sequencer_if;
    logic       Tick;
    logic       Start;
    logic       Stop;
    logic       Clear;
    logic       DivReset;
    logic [3:0] Ones;
    logic [3:0] Tens;
    logic       Running;
    logic       Done;

    modport master (
        output Tick, Start, Stop, Clear,
        input  DivReset, Ones, Tens, Running, Done
    );

    modport slave (
        input  Tick, Start, Stop, Clear,
        output DivReset, Ones, Tens, Running, Done
    );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: start/stop/clear FSM with a two-digit BCD seconds count.
// Define TIMER_COUNTDOWN_EN to count down from MAX_COUNT to 00 instead of up.
module timer_sequencer #(
    parameter int MAX_COUNT = 59
) (
    input logic              Clockin,
    input logic              Resetn,
    timer_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_COUNT % 10);
`ifdef TIMER_COUNTDOWN_EN
    localparam logic [3:0] RLD_T = MAX_T;
    localparam logic [3:0] RLD_O = MAX_O;
`else
    localparam logic [3:0] RLD_T = 4'd0;
    localparam logic [3:0] RLD_O = 4'd0;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;
    logic [3:0] w_step_o;
    logic [3:0] w_step_t;
    logic       w_step_end;
    logic       r_divrst;
    logic       w_divrst_nxt;
    logic       r_running;
    logic       r_done;
    logic       r_start_prev;
    logic       r_stop_prev;
    logic       r_clear_prev;
    logic       w_start_ev;
    logic       w_stop_ev;
    logic       w_clear_ev;

    assign w_start_ev = bus.Start & ~r_start_prev;
    assign w_stop_ev  = bus.Stop  & ~r_stop_prev;
    assign w_clear_ev = bus.Clear & ~r_clear_prev;

    // One BCD step of the count and whether it lands on the terminal value
    always_comb begin
        w_step_o = r_ones;
        w_step_t = r_tens;
`ifdef TIMER_COUNTDOWN_EN
        if (r_ones == 4'd0) begin
            w_step_o = 4'd9;
            w_step_t = r_tens - 4'd1;
        end else begin
            w_step_o = r_ones - 4'd1;
        end
        w_step_end = (w_step_t == 4'd0) && (w_step_o == 4'd0);
`else
        if (r_ones == 4'd9) begin
            w_step_o = 4'd0;
            w_step_t = r_tens + 4'd1;
        end else begin
            w_step_o = r_ones + 4'd1;
        end
        w_step_end = (w_step_t == MAX_T) && (w_step_o == MAX_O);
`endif
    end

    // Next state, next count and divider restart; Clear beats Stop beats Start
    always_comb begin
        w_state_nxt  = r_state;
        w_ones_nxt   = r_ones;
        w_tens_nxt   = r_tens;
        w_divrst_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_clear_ev) begin
                    w_ones_nxt = RLD_O;
                    w_tens_nxt = RLD_T;
                end else if (w_start_ev) begin
                    w_state_nxt  = S_RUN;
                    w_divrst_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_clear_ev) begin
                    w_state_nxt = S_IDLE;
                    w_ones_nxt  = RLD_O;
                    w_tens_nxt  = RLD_T;
                end else if (w_stop_ev) begin
                    w_state_nxt = S_PAUSE;
                end else if (bus.Tick) begin
                    w_ones_nxt = w_step_o;
                    w_tens_nxt = w_step_t;
                    if (w_step_end) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (w_clear_ev) begin
                    w_state_nxt = S_IDLE;
                    w_ones_nxt  = RLD_O;
                    w_tens_nxt  = RLD_T;
                end else if (w_start_ev) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_clear_ev) begin
                    w_state_nxt = S_IDLE;
                    w_ones_nxt  = RLD_O;
                    w_tens_nxt  = RLD_T;
                end else if (w_start_ev) begin
                    w_state_nxt  = S_RUN;
                    w_ones_nxt   = RLD_O;
                    w_tens_nxt   = RLD_T;
                    w_divrst_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, count, registered outputs and button history
    always_ff @(posedge Clockin) begin
        if (!Resetn) begin
            r_state      <= S_IDLE;
            r_ones       <= RLD_O;
            r_tens       <= RLD_T;
            r_divrst     <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_start_prev <= 1'b1;
            r_stop_prev  <= 1'b1;
            r_clear_prev <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ones       <= w_ones_nxt;
            r_tens       <= w_tens_nxt;
            r_divrst     <= w_divrst_nxt;
            r_running    <= (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_DONE);
            r_start_prev <= bus.Start;
            r_stop_prev  <= bus.Stop;
            r_clear_prev <= bus.Clear;
        end
    end

    assign bus.DivReset = r_divrst;
    assign bus.Ones     = r_ones;
    assign bus.Tens     = r_tens;
    assign bus.Running  = r_running;
    assign bus.Done     = r_done;
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed vectors push expected outputs into a queue;
// a monitor pops and compares one entry after every clock edge.
module tb_timer_sequencer;
`ifdef TIMER_COUNTDOWN_EN
    localparam int TB_MAX = 12;
`else
    localparam int TB_MAX = 59;
`endif

    typedef struct packed {
        logic       dv;
        logic [3:0] t;
        logic [3:0] o;
        logic       ru;
        logic       dn;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t  exp_q[$];
    string nm_q[$];

    timer_sequencer_if bus ();

    timer_sequencer #(.MAX_COUNT(TB_MAX)) dut (
        .Clockin (clk),
        .Resetn  (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic cyc(
        input logic rn, input logic tk, input logic st,
        input logic sp, input logic cl,
        input logic dv, input logic [3:0] t, input logic [3:0] o,
        input logic ru, input logic dn, input string nm
    );
        exp_t e;
        @(negedge clk);
        rst_n     = rn;
        bus.Tick  = tk;
        bus.Start = st;
        bus.Stop  = sp;
        bus.Clear = cl;
        e = '{dv: dv, t: t, o: o, ru: ru, dn: dn};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs just after each rising edge
    initial begin
        exp_t  e;
        exp_t  g;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                g = '{dv: bus.DivReset, t: bus.Tens, o: bus.Ones,
                      ru: bus.Running, dn: bus.Done};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL %s: got dv=%0b t=%0d o=%0d run=%0b done=%0b want dv=%0b t=%0d o=%0d run=%0b done=%0b",
                             n, g.dv, g.t, g.o, g.ru, g.dn,
                             e.dv, e.t, e.o, e.ru, e.dn);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.Tick  = 1'b0;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        bus.Clear = 1'b0;
`ifdef TIMER_COUNTDOWN_EN
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, "cd_reset");
        cyc(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, "cd_idle");
        cyc(1, 0, 1, 0, 0, 1, 1, 2, 1, 0, "cd_start");
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, "cd_t1");
        cyc(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, "cd_t2");
        cyc(1, 1, 0, 0, 0, 0, 0, 9, 1, 0, "cd_borrow");
        for (int i = 8; i >= 1; i--) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 4'(i), 1, 0, "cd_tick");
        end
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "cd_done");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "cd_hold");
        cyc(1, 0, 1, 0, 0, 1, 1, 2, 1, 0, "cd_restart");
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, "cd_after_restart");
        cyc(1, 0, 0, 0, 1, 0, 1, 2, 0, 0, "cd_clear");
`else
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset1");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "idle_tick");
        cyc(1, 1, 1, 0, 0, 1, 0, 0, 1, 0, "start_tick_ignored");
        for (int i = 1; i < TB_MAX; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 4'(i / 10), 4'(i % 10), 1, 0, "count_up");
        end
        cyc(1, 1, 0, 0, 0, 0, 5, 9, 0, 1, "terminal");
        cyc(1, 1, 0, 0, 0, 0, 5, 9, 0, 1, "tick_after_done");
        cyc(1, 0, 0, 1, 0, 0, 5, 9, 0, 1, "stop_in_done");
        cyc(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, "restart_from_done");
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 4'(i), 1, 0, "recount");
        end
        cyc(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, "bcd_carry");
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, "c11");
        cyc(1, 1, 0, 0, 0, 0, 1, 2, 1, 0, "c12");
        cyc(1, 1, 0, 1, 0, 0, 1, 2, 0, 0, "stop_with_tick");
        cyc(1, 1, 0, 1, 0, 0, 1, 2, 0, 0, "pause_tick_a");
        cyc(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, "pause_tick_b");
        cyc(1, 1, 1, 0, 0, 0, 1, 2, 1, 0, "resume_no_divrst");
        cyc(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, "resume_tick");
        cyc(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, "clear_stop_start");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_clear");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "hold_start_rst");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "held_start_release");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "start_released");
        cyc(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, "start_again");
        for (int i = 1; i <= 34; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 4'(i / 10), 4'(i % 10), 1, 0, "to_34");
        end
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "mid_reset");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "after_mid_reset");
`endif
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
